// File: rtl/captura_operandos.sv
// captura_operandos
//   Keypad operand capture. Two decimal-style operands are entered one key
//   at a time. Each operand holds up to DIGITS digits, and an ENTER key ends
//   each operand. Once both operands are complete they are held with
//   ops_valid high until the consumer accepts them through ops_ready. A CLEAR
//   key drops everything and restarts capture at the first operand.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   key_req    asynchronous key-held level
//   key_code   code of the held key, stable while key_req is high
//   ops_ready  consumer accepts operands (only meaningful in DONE)
//   op_a       first operand, most recent digit in the low W bits
//   op_b       second operand, same packing
//   ops_valid  both operands complete and held (high exactly in DONE)
//   key_err    one-cycle pulse for each rejected key press
//   digit_cnt  digits captured so far in the current operand
//   state      FSM state: 0 = CAP_A, 1 = CAP_B, 2 = DONE
module captura_operandos #(
  parameter int unsigned W           = 4,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIGIT_MAX   = 9,
  parameter int unsigned ENTER_CODE  = 'hE,
  parameter int unsigned CLEAR_CODE  = 'hC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_req,
  input  logic [W-1:0]                  key_code,
  input  logic                          ops_ready,
  output logic [DIGITS*W-1:0]           op_a,
  output logic [DIGITS*W-1:0]           op_b,
  output logic                          ops_valid,
  output logic                          key_err,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
  output logic [1:0]                    state
);

  localparam int unsigned OPW = DIGITS * W;
  localparam int unsigned CW  = $clog2(DIGITS + 1);
  localparam int unsigned FW  = $clog2(SYNC_STAGES + 1);

  localparam logic [W-1:0]  DIGIT_MAX_K = W'(DIGIT_MAX);
  localparam logic [W-1:0]  ENTER_K     = W'(ENTER_CODE);
  localparam logic [W-1:0]  CLEAR_K     = W'(CLEAR_CODE);
  localparam logic [CW-1:0] DIGITS_K    = CW'(DIGITS);
  localparam logic [FW-1:0] FILL_K      = FW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    CAP_A = 2'd0,
    CAP_B = 2'd1,
    DONE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronizers. The code chain has the same depth as the request
  // chain, so the synchronized code always belongs to the synchronized
  // request.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [W-1:0]           code_sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync_q <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        code_sync_q[i] <= '0;
      end
    end else begin
      req_sync_q     <= {req_sync_q[SYNC_STAGES-2:0], key_req};
      code_sync_q[0] <= key_code;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        code_sync_q[i] <= code_sync_q[i-1];
      end
    end
  end

  logic         req_s;
  logic [W-1:0] code_s;

  assign req_s  = req_sync_q[SYNC_STAGES-1];
  assign code_s = code_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Press detection. After reset the chains hold zeros that do not reflect
  // the real key. The previous-level register is therefore forced high
  // until the chain has refilled. A key held through reset release then
  // looks "already pressed", and it must be released before it can count.
  // ---------------------------------------------------------------------
  logic [FW-1:0] fill_q;
  logic          fill_done;
  logic          prev_q;
  logic          press;

  assign fill_done = (fill_q == FILL_K);
  assign press     = fill_done & req_s & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      if (!fill_done) begin
        fill_q <= fill_q + 1'b1;
      end
      prev_q <= fill_done ? req_s : 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [OPW-1:0] op_a_q, op_a_d;
  logic [OPW-1:0] op_b_q, op_b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           key_err_q, key_err_d;

  logic [OPW-1:0] code_ext;
  logic           is_digit;
  logic           cnt_full;

  always_comb begin
    code_ext         = '0;
    code_ext[W-1:0]  = code_s;
  end

  assign is_digit = (code_s <= DIGIT_MAX_K);
  assign cnt_full = (cnt_q == DIGITS_K);

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    cnt_d     = cnt_q;
    key_err_d = 1'b0;

    case (state_q)
      CAP_A, CAP_B: begin
        if (press) begin
          if (code_s == CLEAR_K) begin
            state_d = CAP_A;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_d   = '0;
          end else if (code_s == ENTER_K) begin
            if (cnt_q != '0) begin
              state_d = (state_q == CAP_A) ? CAP_B : DONE;
              if (state_q == CAP_A) begin
                cnt_d = '0;
              end
            end else begin
              key_err_d = 1'b1;
            end
          end else if (is_digit) begin
            if (!cnt_full) begin
              if (state_q == CAP_A) begin
                op_a_d = (op_a_q << W) | code_ext;
              end else begin
                op_b_d = (op_b_q << W) | code_ext;
              end
              cnt_d = cnt_q + 1'b1;
            end else begin
              key_err_d = 1'b1;
            end
          end else begin
            key_err_d = 1'b1;
          end
        end
      end

      // Presses are ignored here. A press that lands on the handshake edge
      // is discarded along with the operands.
      DONE: begin
        if (ops_ready) begin
          state_d = CAP_A;
          op_a_d  = '0;
          op_b_d  = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = CAP_A;
        op_a_d  = '0;
        op_b_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CAP_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      cnt_q     <= cnt_d;
      key_err_q <= key_err_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign digit_cnt = cnt_q;
  assign key_err   = key_err_q;
  assign state     = state_q;
  assign ops_valid = (state_q == DONE);

endmodule

// File: doc/captura_operandos.md
CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

Interface
REQ-001 Parameter W, default 4: key code / digit width in bits, W >= 4.
REQ-002 Parameter DIGITS, default 3: maximum digits per operand, DIGITS >= 1.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on key inputs, SYNC_STAGES >= 2.
REQ-004 Parameter DIGIT_MAX, default 9: largest key code accepted as a digit.
REQ-005 Parameters ENTER_CODE, default 'hE, and CLEAR_CODE, default 'hC: command key codes, both > DIGIT_MAX.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 key_req  input  1  asynchronous key-held level.
REQ-009 key_code  input  W  code of held key, stable while key_req is high.
REQ-010 ops_ready  input  1  consumer accepts operands.
REQ-011 op_a  output  DIGITS*W  first operand, most recent digit in least significant W bits.
REQ-012 op_b  output  DIGITS*W  second operand, same packing.
REQ-013 ops_valid  output  1  both operands complete and held.
REQ-014 key_err  output  1  one-cycle pulse on a rejected key.
REQ-015 digit_cnt  output  clog2(DIGITS+1)  digits in the operand being captured.
REQ-016 state  output  2  FSM state: CAP_A=0, CAP_B=1, DONE=2.

Function
REQ-017 key_req and key_code shall pass through SYNC_STAGES-deep register chains so the synchronized code is aligned with the synchronized request.
REQ-018 A press event shall be the synchronized key_req rising edge, exactly one event per press regardless of hold length.
REQ-019 key_req first sampled high at edge t0 shall produce its register update visible after edge t0+SYNC_STAGES.
REQ-020 Digit event (code <= DIGIT_MAX) in CAP_A/CAP_B with digit_cnt < DIGITS: operand <= (operand << W) | code, digit_cnt += 1.
REQ-021 Digit event with digit_cnt == DIGITS: operand unchanged, key_err pulses.
REQ-022 Code > DIGIT_MAX other than ENTER_CODE/CLEAR_CODE in CAP_A/CAP_B: ignored, key_err pulses.
REQ-023 ENTER in CAP_A with digit_cnt > 0: go to CAP_B, digit_cnt <= 0; with digit_cnt == 0: stay, key_err pulses.
REQ-024 ENTER in CAP_B with digit_cnt > 0: go to DONE, ops_valid <= 1; with digit_cnt == 0: stay, key_err pulses.
REQ-025 CLEAR in CAP_A or CAP_B: op_a, op_b, digit_cnt <= 0, state <= CAP_A, no key_err.
REQ-026 In DONE, op_a/op_b shall hold and every press event shall be ignored without key_err.
REQ-027 In DONE, ops_valid && ops_ready at an edge: state <= CAP_A, op_a, op_b, digit_cnt <= 0, ops_valid <= 0.
REQ-028 A press event coinciding with the DONE handshake edge shall be discarded.
REQ-029 ops_ready outside DONE shall have no effect; ops_valid shall be high exactly while state == DONE.
REQ-030 key_err shall be high for exactly one cycle per rejected event, registered, aligned with REQ-019.
REQ-031 Unused state encoding 3 shall return to CAP_A with cleared operands on the next edge.

Reset
REQ-032 rst high shall immediately force state=CAP_A, op_a=0, op_b=0, digit_cnt=0, ops_valid=0, key_err=0, synchronizer chains to 0, independent of clk.
REQ-033 rst asserted mid-capture or in DONE shall discard all partial data; a key held through rst release shall not produce a press event until released and pressed again.

Verification
REQ-034 Defaults; press 1,2,ENTER,7,ENTER with ops_ready=0 -> op_a=12'h012, op_b=12'h007, ops_valid=1, state=2, holds.
REQ-035 Press 4,5,6,8 -> op_a=12'h456, key_err one pulse on 8, digit_cnt=3.
REQ-036 key_req high for 50 cycles, code 3 -> digit_cnt increments once; update visible exactly 2 edges after first high sample.
REQ-037 ENTER with digit_cnt=0, then code 'hA -> two key_err pulses, state stays 0; 9,ENTER,CLEAR -> all zero, state=0.
REQ-038 In DONE, ops_ready=1 for one cycle, simultaneous press of 5 -> next cycle state=0, ops_valid=0, op_a=0, digit_cnt=0.
REQ-039 rst asserted between clock edges mid-CAP_B -> outputs zero before next edge; held key ignored until re-pressed.
